rom_sync_loadable: RTL and testbench
====================================

ROM_SYNC_LOADABLE -- requirements
Module: rom_sync_loadable

Interface
- REQ-001 SHALL have parameter ADDR_W, default 13, address width; depth = 2**ADDR_W words.
- REQ-002 SHALL have parameter DATA_W, default 8, word width.
- REQ-003 SHALL have parameter LATENCY, default 1, read latency in cycles; legal values 1 or 2.
- REQ-004 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
- REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
- REQ-006 SHALL have port dl_active  input  1  high while a download session is open.
- REQ-007 SHALL have port dl_wr  input  1  one-cycle write strobe for a download word.
- REQ-008 SHALL have port dl_addr  input  ADDR_W  download word address.
- REQ-009 SHALL have port dl_data  input  DATA_W  download word data.
- REQ-010 SHALL have port a  input  ADDR_W  read address.
- REQ-011 SHALL have port cs_n  input  1  active-low read select.
- REQ-012 SHALL have port dout  output  DATA_W  read data.
- REQ-013 SHALL have port dout_valid  output  1  dout holds data for a completed read.
- REQ-014 SHALL have port busy  output  1  high in states EMPTY and LOADING.
- REQ-015 SHALL have port dl_done  output  1  one-cycle pulse when a session closes.
- REQ-016 SHALL have port dl_count  output  ADDR_W+1  number of words accepted in the current or last session.

Function
- REQ-017 SHALL implement states EMPTY, LOADING, READY, held in a registered state variable.
- REQ-018 SHALL transition EMPTY->LOADING and READY->LOADING on the first cycle dl_active is sampled high.
- REQ-019 SHALL transition LOADING->READY on the first cycle dl_active is sampled low, and assert dl_done in the following cycle for exactly one cycle.
- REQ-020 SHALL clear dl_count to 0 on entry to LOADING.
- REQ-021 SHALL, in LOADING only, write dl_data to memory[dl_addr] and increment dl_count on each cycle dl_wr=1.
- REQ-022 SHALL ignore dl_wr in EMPTY and READY: no memory write and no count change.
- REQ-023 SHALL saturate dl_count at 2**ADDR_W; a further write still updates memory.
- REQ-024 SHALL accept a read only in READY with cs_n=0; read data appears on dout exactly LATENCY cycles after the address is sampled.
- REQ-025 SHALL assert dout_valid in the same cycle that data from an accepted read appears on dout; consecutive accepted reads SHALL pipeline at one per cycle.
- REQ-026 SHALL hold dout at its last value and deassert dout_valid, with the same LATENCY alignment, for cycles in which no read was accepted.
- REQ-027 SHALL, when a read is pending in the pipeline as the block enters LOADING, drop that read: dout_valid stays 0 for it and dout is forced to 0.
- REQ-028 SHALL keep dout=0 and dout_valid=0 throughout EMPTY and LOADING.
- REQ-029 SHALL give precedence to the download: when dl_active rises while cs_n=0, no read is accepted in that cycle.
- REQ-030 SHALL infer the memory as single-clock block RAM; no combinational path from a to dout.

Reset
- REQ-031 SHALL, when reset_n=0 at a clock edge, force state=EMPTY, dout=0, dout_valid=0, dl_done=0, dl_count=0, and flush the read pipeline.
- REQ-032 SHALL abort a download on reset: the state returns to EMPTY, memory contents written so far are retained and no dl_done is generated.
- REQ-033 SHALL NOT clear memory on reset.

Verification
- REQ-034 Reset, then 4 cycles idle with cs_n=0 and a=0x0005 -> busy=1, dout=0x00, dout_valid=0 throughout.
- REQ-035 Download words 0x00..0xFF to addresses 0..255, then drop dl_active -> dl_count=256, dl_done=1 for one cycle, busy=0.
- REQ-036 LATENCY=1: read a=0x0010, then 0x0011 back-to-back -> dout=0x10 with valid 1 cycle later, then 0x11; LATENCY=2 -> the same values 2 cycles after each sample.
- REQ-037 Raise dl_active in the cycle after a read of 0x0020 is issued -> dout_valid never rises for it, busy=1, dout=0x00.
- REQ-038 Pulse reset_n low after 10 of 20 download writes -> EMPTY, dl_count=0, no dl_done; a new 20-word session then yields dl_count=20.
- REQ-039 Pulse dl_wr with dl_active=0 in READY at address 0x0003 with data 0xAA -> a read of 0x0003 still returns its prior value and dl_count is unchanged.

Source files
------------

// File: rtl/rom_sync_loadable.sv
`default_nettype none
// rom_sync_loadable: single-clock block-RAM ROM whose contents are downloaded through a
// session interface, with a 1- or 2-cycle registered read pipeline.
// Revision 1.0
module rom_sync_loadable #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [DATA_W-1:0] dl_data,
  input  logic [ADDR_W-1:0] a,
  input  logic              cs_n,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              dl_done,
  output logic [ADDR_W:0]   dl_count
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              dl_done_q, dl_done_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr_en;
  logic              rd_acc;
  logic              flush;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_comb begin
    state_d   = state_q;
    dl_done_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      ST_EMPTY:   if (dl_active) state_d = ST_LOADING;
      ST_READY:   if (dl_active) state_d = ST_LOADING;
      ST_LOADING: begin
        if (!dl_active) begin
          state_d   = ST_READY;
          dl_done_d = 1'b1;
        end
      end
      default:    state_d = ST_EMPTY;
    endcase

    if (state_q != ST_LOADING && state_d == ST_LOADING) begin
      cnt_d = '0;
    end else if (wr_en && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  assign wr_en  = (state_q == ST_LOADING) && dl_wr;
  // A rising dl_active blocks the read in the same cycle: download has precedence.
  assign rd_acc = (state_q == ST_READY) && !cs_n && !dl_active;
  // Anything in flight is dropped whenever the next cycle is not READY.
  assign flush  = (state_d != ST_READY);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_EMPTY;
      dl_done_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      dl_done_q <= dl_done_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[dl_addr] <= dl_data;
  end

  generate
    if (LATENCY == 2) begin : g_lat2
      logic [DATA_W-1:0] ram_q;
      logic              v1_q;
      logic [DATA_W-1:0] dout_q;
      logic              valid_q;

      always_ff @(posedge clk) begin
        if (rd_acc) ram_q <= mem_q[a];
      end

      always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
          v1_q    <= 1'b0;
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          v1_q    <= rd_acc;
          valid_q <= v1_q;
          if (v1_q) dout_q <= ram_q;
        end
      end

      assign dout       = dout_q;
      assign dout_valid = valid_q;
    end else begin : g_lat1
      logic [DATA_W-1:0] dout_q;
      logic              valid_q;

      always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) dout_q <= mem_q[a];
        end
      end

      assign dout       = dout_q;
      assign dout_valid = valid_q;
    end
  endgenerate

  assign busy     = (state_q != ST_READY);
  assign dl_done  = dl_done_q;
  assign dl_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_sync_loadable.sv
`default_nettype none
// tb_rom_sync_loadable: directed checks of two instances (LATENCY=1 and LATENCY=2)
// driven from one shared stimulus stream.
module tb_rom_sync_loadable;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk;
  logic          reset_n;
  logic          dl_active;
  logic          dl_wr;
  logic [AW-1:0] dl_addr;
  logic [DW-1:0] dl_data;
  logic [AW-1:0] a;
  logic          cs_n;

  logic [DW-1:0] dout1, dout2;
  logic          valid1, valid2;
  logic          busy1, busy2;
  logic          done1, done2;
  logic [AW:0]   cnt1, cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  rom_sync_loadable #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) u_l1 (
    .clk(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .a(a), .cs_n(cs_n),
    .dout(dout1), .dout_valid(valid1), .busy(busy1), .dl_done(done1), .dl_count(cnt1)
  );

  rom_sync_loadable #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(2)) u_l2 (
    .clk(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .a(a), .cs_n(cs_n),
    .dout(dout2), .dout_valid(valid2), .busy(busy2), .dl_done(done2), .dl_count(cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy1"},  32'(busy1),  32'd1);
    chk({tag, "_dout1"},  32'(dout1),  32'h0);
    chk({tag, "_valid1"}, 32'(valid1), 32'd0);
    chk({tag, "_busy2"},  32'(busy2),  32'd1);
    chk({tag, "_dout2"},  32'(dout2),  32'h0);
    chk({tag, "_valid2"}, 32'(valid2), 32'd0);
  endtask

  // Single read: LATENCY=1 result one cycle after sampling, LATENCY=2 one cycle later.
  task automatic rd(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string tag);
    cs_n = 1'b0;
    a    = addr;
    tick();
    cs_n = 1'b1;
    chk({tag, "_l1_dout"},  32'(dout1),  32'(exp));
    chk({tag, "_l1_valid"}, 32'(valid1), 32'd1);
    chk({tag, "_l2_early"}, 32'(valid2), 32'd0);
    tick();
    chk({tag, "_l2_dout"},  32'(dout2),  32'(exp));
    chk({tag, "_l2_valid"}, 32'(valid2), 32'd1);
    chk({tag, "_l1_hold"},  32'(dout1),  32'(exp));
    chk({tag, "_l1_idle"},  32'(valid1), 32'd0);
    tick();
  endtask

  task automatic load(input logic [AW-1:0] base, input int n, input logic [DW-1:0] dbase);
    dl_active = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      dl_wr   = 1'b1;
      dl_addr = base + AW'(i);
      dl_data = dbase + DW'(i);
      tick();
    end
    dl_wr = 1'b0;
  endtask

  task automatic close_session(input logic [AW:0] exp_cnt, input string tag);
    dl_active = 1'b0;
    tick();
    chk({tag, "_done1"}, 32'(done1), 32'd1);
    chk({tag, "_done2"}, 32'(done2), 32'd1);
    chk({tag, "_busy"},  32'(busy1), 32'd0);
    chk({tag, "_cnt1"},  32'(cnt1),  32'(exp_cnt));
    chk({tag, "_cnt2"},  32'(cnt2),  32'(exp_cnt));
    tick();
    chk({tag, "_done_off"}, 32'(done1), 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    dl_addr   = '0;
    dl_data   = '0;
    a         = '0;
    cs_n      = 1'b1;
    tick();
    tick();
    chk_idle("rst");
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_cnt",  32'(cnt1),  32'd0);

    // Idle in EMPTY with a read requested: nothing may come out.
    reset_n = 1'b1;
    cs_n    = 1'b0;
    a       = 13'h0005;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_idle($sformatf("empty%0d", i));
    end
    cs_n = 1'b1;

    // First session: 256 words, data equals address.
    load(13'h0000, 256, 8'h00);
    chk("load_busy", 32'(busy1), 32'd1);
    chk("load_cnt",  32'(cnt1),  32'd256);
    close_session(14'd256, "s1");

    // Back-to-back reads of 0x10 then 0x11.
    cs_n = 1'b0;
    a    = 13'h0010;
    tick();
    chk("b2b_l1_d0", 32'(dout1),  32'h10);
    chk("b2b_l1_v0", 32'(valid1), 32'd1);
    chk("b2b_l2_v0", 32'(valid2), 32'd0);
    a = 13'h0011;
    tick();
    cs_n = 1'b1;
    chk("b2b_l1_d1", 32'(dout1),  32'h11);
    chk("b2b_l1_v1", 32'(valid1), 32'd1);
    chk("b2b_l2_d1", 32'(dout2),  32'h10);
    chk("b2b_l2_v1", 32'(valid2), 32'd1);
    tick();
    chk("b2b_l1_hold", 32'(dout1),  32'h11);
    chk("b2b_l1_v2",   32'(valid1), 32'd0);
    chk("b2b_l2_d2",   32'(dout2),  32'h11);
    chk("b2b_l2_v2",   32'(valid2), 32'd1);
    tick();
    chk("b2b_l2_hold", 32'(dout2),  32'h11);
    chk("b2b_l2_v3",   32'(valid2), 32'd0);

    rd(13'h00FF, 8'hFF, "rd_ff");

    // Read of 0x20, then a session opens the next cycle: the LATENCY=2 read is dropped.
    cs_n = 1'b0;
    a    = 13'h0020;
    tick();
    chk("drop_l1_v", 32'(valid1), 32'd1);
    chk("drop_l2_v", 32'(valid2), 32'd0);
    cs_n      = 1'b1;
    dl_active = 1'b1;
    tick();
    chk_idle("drop_a");
    tick();
    chk_idle("drop_b");
    chk("drop_cnt_clr", 32'(cnt1), 32'd0);
    close_session(14'd0, "s_empty");

    // dl_active and cs_n together in READY: the read is not accepted.
    cs_n      = 1'b0;
    a         = 13'h0030;
    dl_active = 1'b1;
    tick();
    chk_idle("prec_a");
    tick();
    chk_idle("prec_b");
    cs_n = 1'b1;
    close_session(14'd0, "s_prec");

    // Aborted session: 10 of 20 words, then reset.
    load(13'h0100, 10, 8'h50);
    dl_active = 1'b0;
    reset_n   = 1'b0;
    tick();
    chk("abort_busy", 32'(busy1), 32'd1);
    chk("abort_cnt",  32'(cnt1),  32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("abort_done2", 32'(done1), 32'd0);
    chk("abort_empty", 32'(busy2), 32'd1);
    load(13'h0200, 20, 8'h80);
    close_session(14'd20, "s_after");
    rd(13'h0105, 8'h55, "rd_kept");
    rd(13'h0213, 8'h93, "rd_new");
    rd(13'h0020, 8'h20, "rd_old");

    // dl_wr outside a session is ignored.
    dl_wr   = 1'b1;
    dl_addr = 13'h0003;
    dl_data = 8'hAA;
    tick();
    dl_wr = 1'b0;
    chk("ign_cnt", 32'(cnt1), 32'd20);
    rd(13'h0003, 8'h03, "rd_ign");

    // Full-depth session plus one extra write: count saturates, memory still written.
    dl_active = 1'b1;
    tick();
    for (int i = 0; i < 8193; i++) begin
      dl_wr   = 1'b1;
      dl_addr = (i == 8192) ? 13'h0007 : AW'(i);
      dl_data = (i == 8192) ? 8'hEE : (DW'(i) ^ 8'hC3);
      tick();
    end
    dl_wr = 1'b0;
    chk("sat_cnt", 32'(cnt1), 32'h2000);
    close_session(14'h2000, "s_sat");
    rd(13'h0007, 8'hEE, "rd_sat_last");
    rd(13'h1FFF, 8'h3C, "rd_sat_top");
    rd(13'h0010, 8'hD3, "rd_sat_mid");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
